// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter that feeds bytes to a uart_tx.
// Each accepted byte holds tx_start for one bit time, then busy stays high for the rest of the frame.
module uart_tx_arb #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_BITS   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] din,
    output logic       busy,
    output logic       grant_id
);

    localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
    localparam int CNT_W = ($clog2(FRAME_CYCLES + 1) > 16) ? $clog2(FRAME_CYCLES + 1) : 16;
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       din_q, din_d;
    logic             grant_q, grant_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic             win_valid_s;
    logic             win_id_s;
    logic             accept_s;

    // Winner selection: a lone requester wins outright; the pointer breaks ties.
    always_comb begin
        win_valid_s = req0_valid | req1_valid;
        win_id_s    = 1'b0;
        if (req0_valid && req1_valid) begin
            win_id_s = ptr_q;
        end else if (req1_valid) begin
            win_id_s = 1'b1;
        end else begin
            win_id_s = 1'b0;
        end
    end

    // Ready is masked during reset because the state register already reads IDLE then.
    always_comb begin
        accept_s   = (state_q == IDLE) && win_valid_s && !rst;
        req0_ready = accept_s && !win_id_s;
        req1_ready = accept_s && win_id_s;
    end

    // Next-state logic; the frame counter restarts at every START entry.
    always_comb begin
        state_d     = state_q;
        din_d       = din_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    din_d       = win_id_s ? req1_data : req0_data;
                    grant_d     = win_id_s;
                    ptr_d       = !win_id_s;
                    frame_cnt_d = {CNT_W{1'b0}};
                    state_d     = START;
                end else begin
                    frame_cnt_d = {CNT_W{1'b0}};
                end
            end
            START: begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1'b1);
                if (frame_cnt_q == START_LAST) begin
                    state_d = WAIT;
                end else begin
                    state_d = START;
                end
            end
            WAIT: begin
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_d = {CNT_W{1'b0}};
                    state_d     = IDLE;
                end else begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1'b1);
                    state_d     = WAIT;
                end
            end
            default: begin
                frame_cnt_d = {CNT_W{1'b0}};
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            din_q       <= 8'h00;
            grant_q     <= 1'b0;
            ptr_q       <= 1'b0;
            frame_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            din_q       <= din_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Outputs decode straight from registers so reset clears them at once.
    assign tx_start = (state_q == START);
    assign busy     = (state_q == START) || (state_q == WAIT);
    assign din      = din_q;
    assign grant_id = grant_q;

endmodule
